decode_exec_pipe: RTL and testbench

DECODE_EXEC_PIPE -- requirements
Module: decode_exec_pipe

---
 rtl/decode_exec_pkg.sv | 66 ++++++
 rtl/seq_multiplier.sv | 52 +++++
 rtl/decode_exec_pipe.sv | 178 +++++++++++++++++
 tb/tb_decode_exec_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_exec_pkg.sv
// Shared decode definitions for decode_exec_pipe: opcodes, instruction field positions, legality helpers.
// The MUL_BUSY state type exists only when DECODE_EXEC_MUL_EN is defined.
package decode_exec_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00,
        OP_SUB  = 6'h01,
        OP_AND  = 6'h02,
        OP_OR   = 6'h03,
        OP_XOR  = 6'h04,
        OP_SLL  = 6'h05,
        OP_SRL  = 6'h06,
        OP_ADDI = 6'h08,
        OP_MUL  = 6'h10,
        OP_NOP  = 6'h3F
    } opcode_e;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS1_MSB = 20;
    localparam int unsigned RS1_LSB = 16;
    localparam int unsigned RS2_MSB = 15;
    localparam int unsigned RS2_LSB = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

`ifdef DECODE_EXEC_MUL_EN
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;
`endif

    // Any opcode not listed here retires as illegal.
    function automatic logic op_is_known(input logic [5:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_ADDI, OP_NOP: op_is_known = 1'b1;
`ifdef DECODE_EXEC_MUL_EN
            OP_MUL:                          op_is_known = 1'b1;
`endif
            default:                         op_is_known = 1'b0;
        endcase
    endfunction

    // Ops that use rd and rs1 (and therefore write the register file).
    function automatic logic op_uses_regs(input logic [5:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_ADDI, OP_MUL: op_uses_regs = 1'b1;
            default:                         op_uses_regs = 1'b0;
        endcase
    endfunction

    // ADDI reuses the rs2 bits as immediate, so only R-type ops check rs2.
    function automatic logic op_uses_rs2(input logic [5:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_MUL: op_uses_rs2 = 1'b1;
            default:                op_uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, XLEN cycles after i_start.
// o_done_c/o_product_c are combinational and valid during the cycle of the final iteration.
module seq_multiplier #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done_c,
    output logic [XLEN-1:0] o_product_c
);

    localparam int unsigned CNTW = $clog2(XLEN + 1);

    logic            r_busy;
    logic [CNTW-1:0] r_count;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] w_acc_next;

    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done_c    = r_busy && (r_count == CNTW'(1));
    assign o_product_c = w_acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_count  <= CNTW'(XLEN);
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CNTW'(1);
            if (r_count == CNTW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/decode_exec_pipe.sv
// Single-issue decode/execute stage with register file; single-cycle ALU ops retire one cycle after accept.
// Define DECODE_EXEC_MUL_EN to build the multi-cycle MUL path (seq_multiplier, MUL_BUSY state).
module decode_exec_pipe
    import decode_exec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [4:0]      result_rd,
    output logic            reg_write_enable,
    output logic            illegal
);

    localparam int unsigned IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned SHW  = $clog2(XLEN);

    logic [5:0]        w_opc;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic signed [15:0] w_imm;
    logic [XLEN-1:0]   w_imm_ext;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic [XLEN-1:0]   w_alu;
    logic              w_legal;
    logic              w_mul_op;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_retire;
    logic [XLEN-1:0]   w_ret_data;
    logic [4:0]        w_ret_rd;
    logic              w_ret_we;
    logic              w_ret_ill;
    logic [XLEN-1:0]   r_regs [NREGS];

    assign w_opc     = instruction[OPC_MSB:OPC_LSB];
    assign w_rd      = instruction[RD_MSB:RD_LSB];
    assign w_rs1     = instruction[RS1_MSB:RS1_LSB];
    assign w_rs2     = instruction[RS2_MSB:RS2_LSB];
    assign w_imm     = instruction[IMM_MSB:IMM_LSB];
    assign w_imm_ext = XLEN'(w_imm);
    assign w_accept  = instr_valid && instr_ready;
    assign w_mul_op  = w_legal && (w_opc == OP_MUL);

    // Register reads: entry 0 and out-of-range indices read as zero.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != '0 && 32'(w_rs1) < NREGS) w_rs1_val = r_regs[w_rs1[IDXW-1:0]];
        if (w_rs2 != '0 && 32'(w_rs2) < NREGS) w_rs2_val = r_regs[w_rs2[IDXW-1:0]];
    end

    always_comb begin
        w_legal = op_is_known(w_opc);
        if (op_uses_regs(w_opc) && (32'(w_rd) >= NREGS || 32'(w_rs1) >= NREGS)) w_legal = 1'b0;
        if (op_uses_rs2(w_opc) && 32'(w_rs2) >= NREGS) w_legal = 1'b0;
    end

    always_comb begin
        w_alu = '0;
        case (w_opc)
            OP_ADD:  w_alu = w_rs1_val + w_rs2_val;
            OP_SUB:  w_alu = w_rs1_val - w_rs2_val;
            OP_AND:  w_alu = w_rs1_val & w_rs2_val;
            OP_OR:   w_alu = w_rs1_val | w_rs2_val;
            OP_XOR:  w_alu = w_rs1_val ^ w_rs2_val;
            OP_SLL:  w_alu = w_rs1_val << w_rs2_val[SHW-1:0];
            OP_SRL:  w_alu = w_rs1_val >> w_rs2_val[SHW-1:0];
            OP_ADDI: w_alu = w_rs1_val + w_imm_ext;
            default: w_alu = '0;
        endcase
    end

`ifdef DECODE_EXEC_MUL_EN
    state_e          r_state;
    state_e          w_next_state;
    logic            r_instr_ready;
    logic [4:0]      r_mul_rd;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_product;

    seq_multiplier #(.XLEN(XLEN)) u_mul (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_mul_start),
        .i_a         (w_rs1_val),
        .i_b         (w_rs2_val),
        .o_done_c    (w_mul_done),
        .o_product_c (w_mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b1;
            r_mul_rd      <= '0;
        end else begin
            r_state       <= w_next_state;
            r_instr_ready <= (w_next_state == ST_IDLE);
            if (w_mul_start) r_mul_rd <= w_rd;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_mul_start) w_next_state = ST_MUL_BUSY;
            ST_MUL_BUSY: if (w_mul_done)  w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    assign instr_ready = r_instr_ready;
`else
    assign instr_ready = 1'b1;
`endif

    // Retirement select: single-cycle op at accept, or MUL completion.
    always_comb begin
        w_mul_start = 1'b0;
        w_retire    = 1'b0;
        w_ret_data  = '0;
        w_ret_rd    = '0;
        w_ret_we    = 1'b0;
        w_ret_ill   = 1'b0;
        if (w_accept && !w_mul_op) begin
            w_retire   = 1'b1;
            w_ret_rd   = w_rd;
            w_ret_ill  = !w_legal;
            w_ret_data = w_legal ? w_alu : '0;
            w_ret_we   = w_legal && op_uses_regs(w_opc) && (w_rd != '0);
        end
`ifdef DECODE_EXEC_MUL_EN
        if (w_accept && w_mul_op) w_mul_start = 1'b1;
        if (w_mul_done) begin
            w_retire   = 1'b1;
            w_ret_rd   = r_mul_rd;
            w_ret_data = w_mul_product;
            w_ret_we   = (r_mul_rd != '0);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result           <= '0;
            result_valid     <= 1'b0;
            result_rd        <= '0;
            reg_write_enable <= 1'b0;
            illegal          <= 1'b0;
        end else begin
            result_valid     <= w_retire;
            reg_write_enable <= w_ret_we;
            illegal          <= w_ret_ill;
            if (w_retire) begin
                result    <= w_ret_data;
                result_rd <= w_ret_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else if (w_ret_we) begin
            r_regs[w_ret_rd[IDXW-1:0]] <= w_ret_data;
        end
    end

endmodule

// File: tb/tb_decode_exec_pipe.sv
// Directed bench for decode_exec_pipe: a 32-bit/16-entry instance and an 8-bit/8-entry instance.
// MUL sequences run when DECODE_EXEC_MUL_EN is defined; otherwise opcode 0x10 must retire illegal.
module tb_decode_exec_pipe;

    localparam logic [5:0] O_ADD = 6'h00, O_SUB = 6'h01, O_AND = 6'h02, O_OR = 6'h03;
    localparam logic [5:0] O_XOR = 6'h04, O_SLL = 6'h05, O_SRL = 6'h06, O_ADDI = 6'h08;
    localparam logic [5:0] O_MUL = 6'h10, O_NOP = 6'h3F, O_BAD = 6'h2A;

    typedef struct {
        logic        sel;
        logic [31:0] instr;
        logic [31:0] res;
        logic        we;
        logic        ill;
        logic [4:0]  rd;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        v32, rdy32, rv32, we32, ill32;
    logic [31:0] ins32, res32;
    logic [4:0]  rrd32;
    logic        v8, rdy8, rv8, we8, ill8;
    logic [31:0] ins8;
    logic [7:0]  res8;
    logic [4:0]  rrd8;

    int   checks;
    int   failures;
    vec_t vecs [48];
    int   nvec;

    decode_exec_pipe #(.XLEN(32), .NREGS(16)) u_dut (
        .clk(clk), .reset(reset), .instr_valid(v32), .instr_ready(rdy32), .instruction(ins32),
        .result(res32), .result_valid(rv32), .result_rd(rrd32), .reg_write_enable(we32), .illegal(ill32)
    );

    decode_exec_pipe #(.XLEN(8), .NREGS(8)) u_dut8 (
        .clk(clk), .reset(reset), .instr_valid(v8), .instr_ready(rdy8), .instruction(ins8),
        .result(res8), .result_valid(rv8), .result_rd(rrd8), .reg_write_enable(we8), .illegal(ill8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rt(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'd0};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s #%0d got=%h exp=%h", nm, idx, got, exp);
        end
    endtask

    task automatic add(input logic sel, input logic [31:0] instr, input logic [31:0] res,
                       input logic we, input logic ill, input logic [4:0] rd);
        vecs[nvec] = '{sel, instr, res, we, ill, rd};
        nvec++;
    endtask

    task automatic check_vec(input int i);
        if (!vecs[i].sel) begin
            chk("valid32", i, 32'(rv32), 32'd1);
            chk("result32", i, res32, vecs[i].res);
            chk("we32", i, 32'(we32), 32'(vecs[i].we));
            chk("illegal32", i, 32'(ill32), 32'(vecs[i].ill));
            chk("rd32", i, 32'(rrd32), 32'(vecs[i].rd));
        end else begin
            chk("valid8", i, 32'(rv8), 32'd1);
            chk("result8", i, 32'(res8), vecs[i].res);
            chk("we8", i, 32'(we8), 32'(vecs[i].we));
            chk("illegal8", i, 32'(ill8), 32'(vecs[i].ill));
            chk("rd8", i, 32'(rrd8), 32'(vecs[i].rd));
        end
    endtask

    // One instruction on the 32-bit instance, checked one cycle after accept.
    task automatic issue32(input string nm, input logic [31:0] instr, input logic [31:0] exp);
        @(negedge clk);
        v32 = 1'b1;
        ins32 = instr;
        @(negedge clk);
        v32 = 1'b0;
        chk({nm, "_valid"}, 0, 32'(rv32), 32'd1);
        chk(nm, 0, res32, exp);
    endtask

    initial begin
        int vcount;
        checks = 0;
        failures = 0;
        nvec = 0;
        reset = 1'b1;
        v32 = 1'b0; ins32 = '0;
        v8 = 1'b0;  ins8 = '0;

        repeat (2) @(negedge clk);
        chk("rst_result", 0, res32, 32'd0);
        chk("rst_valid", 0, 32'(rv32), 32'd0);
        chk("rst_rd", 0, 32'(rrd32), 32'd0);
        chk("rst_we", 0, 32'(we32), 32'd0);
        chk("rst_illegal", 0, 32'(ill32), 32'd0);
        chk("rst_ready", 0, 32'(rdy32), 32'd1);
        chk("rst_ready8", 0, 32'(rdy8), 32'd1);
        chk("rst_valid8", 0, 32'(rv8), 32'd0);
        reset = 1'b0;

        add(0, it(O_ADDI, 5'd1, 5'd0, 16'd5),      32'd5,          1, 0, 5'd1);
        add(0, it(O_ADDI, 5'd2, 5'd0, 16'hFFFD),   32'hFFFF_FFFD,  1, 0, 5'd2);
        add(0, rt(O_ADD,  5'd3, 5'd1, 5'd2),       32'd2,          1, 0, 5'd3);
        add(0, rt(O_ADD,  5'd0, 5'd1, 5'd1),       32'd10,         0, 0, 5'd0);
        add(0, rt(O_ADD,  5'd4, 5'd0, 5'd0),       32'd0,          1, 0, 5'd4);
        add(0, rt(O_SUB,  5'd5, 5'd1, 5'd2),       32'd8,          1, 0, 5'd5);
        add(0, rt(O_AND,  5'd6, 5'd1, 5'd2),       32'd5,          1, 0, 5'd6);
        add(0, rt(O_OR,   5'd7, 5'd1, 5'd2),       32'hFFFF_FFFD,  1, 0, 5'd7);
        add(0, rt(O_XOR,  5'd8, 5'd1, 5'd2),       32'hFFFF_FFF8,  1, 0, 5'd8);
        add(0, rt(O_SLL,  5'd9, 5'd1, 5'd3),       32'd20,         1, 0, 5'd9);
        add(0, rt(O_SRL,  5'd10, 5'd2, 5'd3),      32'h3FFF_FFFF,  1, 0, 5'd10);
        add(0, it(O_ADDI, 5'd12, 5'd0, 16'd33),    32'd33,         1, 0, 5'd12);
        add(0, rt(O_SLL,  5'd13, 5'd1, 5'd12),     32'd10,         1, 0, 5'd13);
        add(0, {O_NOP, 26'd0},                     32'd0,          0, 0, 5'd0);
        add(0, rt(O_BAD,  5'd11, 5'd1, 5'd1),      32'd0,          0, 1, 5'd11);
        add(0, rt(O_ADD,  5'd20, 5'd1, 5'd1),      32'd0,          0, 1, 5'd20);
        add(0, rt(O_ADD,  5'd0, 5'd11, 5'd0),      32'd0,          0, 0, 5'd0);
        add(0, rt(O_ADD,  5'd1, 5'd16, 5'd1),      32'd0,          0, 1, 5'd1);
        add(0, rt(O_ADD,  5'd0, 5'd1, 5'd0),       32'd5,          0, 0, 5'd0);
        add(0, it(O_ADDI, 5'd14, 5'd0, 16'h7FFF),  32'h0000_7FFF,  1, 0, 5'd14);
        add(0, rt(O_ADD,  5'd15, 5'd14, 5'd2),     32'h0000_7FFC,  1, 0, 5'd15);
        add(0, it(O_ADDI, 5'd0, 5'd1, 16'd1),      32'd6,          0, 0, 5'd0);
        add(0, rt(O_SRL,  5'd0, 5'd2, 5'd12),      32'h7FFF_FFFE,  0, 0, 5'd0);
        add(1, it(O_ADDI, 5'd1, 5'd0, 16'h00FF),   32'hFF,         1, 0, 5'd1);
        add(1, it(O_ADDI, 5'd2, 5'd0, 16'd1),      32'h01,         1, 0, 5'd2);
        add(1, rt(O_ADD,  5'd3, 5'd1, 5'd2),       32'h00,         1, 0, 5'd3);
        add(1, it(O_ADDI, 5'd4, 5'd0, 16'd9),      32'h09,         1, 0, 5'd4);
        add(1, rt(O_SLL,  5'd5, 5'd2, 5'd4),       32'h02,         1, 0, 5'd5);
        add(1, rt(O_SRL,  5'd6, 5'd1, 5'd4),       32'h7F,         1, 0, 5'd6);
        add(1, it(O_ADDI, 5'd7, 5'd0, 16'hFFFF),   32'hFF,         1, 0, 5'd7);
        add(1, rt(O_ADD,  5'd8, 5'd1, 5'd1),       32'h00,         0, 1, 5'd8);
        add(1, rt(O_ADD,  5'd0, 5'd1, 5'd0),       32'hFF,         0, 0, 5'd0);

        // Back-to-back issue: vector i is driven while vector i-1 is checked.
        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            if (i > 0) check_vec(i - 1);
            v32   = !vecs[i].sel;
            v8    = vecs[i].sel;
            ins32 = vecs[i].instr;
            ins8  = vecs[i].instr;
        end
        @(negedge clk);
        check_vec(nvec - 1);
        v32 = 1'b0;
        v8  = 1'b0;
        @(negedge clk);
        chk("pulse_end32", 0, 32'(rv32), 32'd0);
        chk("pulse_end8", 0, 32'(rv8), 32'd0);

        issue32("addi_r9", it(O_ADDI, 5'd9, 5'd0, 16'd7), 32'd7);
        issue32("addi_r10", it(O_ADDI, 5'd10, 5'd0, 16'd6), 32'd6);

`ifdef DECODE_EXEC_MUL_EN
        begin
            int busy_cycles;
            int early_valid;
            busy_cycles = 0;
            early_valid = 0;
            @(negedge clk);
            v32 = 1'b1;
            ins32 = rt(O_MUL, 5'd11, 5'd9, 5'd10);
            @(negedge clk);
            ins32 = rt(O_ADD, 5'd0, 5'd11, 5'd0);
            for (int k = 0; k < 32; k++) begin
                if (!rdy32) busy_cycles++;
                if (rv32) early_valid++;
                @(negedge clk);
            end
            chk("mul_busy_cycles", 0, 32'(busy_cycles), 32'd32);
            chk("mul_early_valid", 0, 32'(early_valid), 32'd0);
            chk("mul_valid", 0, 32'(rv32), 32'd1);
            chk("mul_result", 0, res32, 32'd42);
            chk("mul_rd", 0, 32'(rrd32), 32'd11);
            chk("mul_we", 0, 32'(we32), 32'd1);
            chk("mul_ready_after", 0, 32'(rdy32), 32'd1);
            @(negedge clk);
            v32 = 1'b0;
            chk("held_valid", 0, 32'(rv32), 32'd1);
            chk("held_read_r11", 0, res32, 32'd42);
            chk("held_rd", 0, 32'(rrd32), 32'd0);

            @(negedge clk);
            v32 = 1'b1;
            ins32 = rt(O_MUL, 5'd12, 5'd9, 5'd10);
            @(negedge clk);
            v32 = 1'b0;
            repeat (5) @(negedge clk);
        end
`else
        issue32("mul_disabled", rt(O_MUL, 5'd11, 5'd9, 5'd10), 32'd0);
        chk("mul_disabled_ill", 0, 32'(ill32), 32'd1);
        chk("mul_disabled_we", 0, 32'(we32), 32'd0);
        chk("mul_disabled_ready", 0, 32'(rdy32), 32'd1);
        issue32("mul_disabled_r11", rt(O_ADD, 5'd0, 5'd11, 5'd0), 32'd0);
`endif

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (rv32) vcount++;
            @(negedge clk);
        end
        chk("post_rst_no_valid", 0, 32'(vcount), 32'd0);
        chk("post_rst_ready", 0, 32'(rdy32), 32'd1);
        issue32("post_rst_r1", rt(O_ADD, 5'd0, 5'd1, 5'd0), 32'd0);
        issue32("post_rst_r9", rt(O_ADD, 5'd0, 5'd9, 5'd0), 32'd0);
        issue32("post_rst_r12", rt(O_ADD, 5'd0, 5'd12, 5'd0), 32'd0);
        issue32("post_rst_r15", rt(O_ADD, 5'd0, 5'd15, 5'd0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
